// File: rtl/riscv_defines.sv
// Shared definitions for the RI5CY hardware-loop blocks.
package riscv_defines;

    localparam int unsigned HWLP_DATA_W   = 32;
    localparam int unsigned HWLP_WE_W     = 3;
    localparam int unsigned HWLP_WE_START = 0;
    localparam int unsigned HWLP_WE_END   = 1;
    localparam int unsigned HWLP_WE_CNT   = 2;
    localparam int unsigned N_HWLP        = 2;

    // Addresses are halfword aligned; bit 0 is always stored as zero.
    function automatic logic [HWLP_DATA_W-1:0] hwlp_align(input logic [HWLP_DATA_W-1:0] addr);
        return addr & ~HWLP_DATA_W'(1);
    endfunction

endpackage

// File: rtl/riscv_hwloop_counter.sv
// One hardware-loop iteration counter with saturating decrement and in-flight flag.
module riscv_hwloop_counter
    import riscv_defines::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [HWLP_DATA_W-1:0] cnt_data_i,
    input  logic                   cnt_we_i,
    input  logic                   dec_i,
    input  logic                   id_advance_i,
    output logic [HWLP_DATA_W-1:0] counter_o,
    output logic                   active_o,
    output logic                   dec_pending_o
);

    // A counter write overrides a same-cycle decrement; zero saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_o <= '0;
        end else if (cnt_we_i) begin
            counter_o <= cnt_data_i;
        end else if (dec_i && (counter_o != '0)) begin
            counter_o <= counter_o - HWLP_DATA_W'(1);
        end
    end

    // Decrement issued while its end-of-loop instruction still sits in ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_pending_o <= 1'b0;
        end else if (id_advance_i || cnt_we_i) begin
            dec_pending_o <= 1'b0;
        end else if (dec_i) begin
            dec_pending_o <= 1'b1;
        end
    end

    assign active_o = (counter_o != '0);

endmodule

// File: rtl/riscv_hwloop_regfile.sv
// Hardware-loop start/end/counter storage written from ID and decremented by the loop controller.
module riscv_hwloop_regfile
    import riscv_defines::*;
#(
    parameter int unsigned N_REGS     = N_HWLP,
    parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [HWLP_DATA_W-1:0]              hwlp_start_data_i,
    input  logic [HWLP_DATA_W-1:0]              hwlp_end_data_i,
    input  logic [HWLP_DATA_W-1:0]              hwlp_cnt_data_i,
    input  logic [HWLP_WE_W-1:0]                hwlp_we_i,
    input  logic [N_REG_BITS-1:0]               hwlp_regid_i,
    input  logic                                valid_i,
    input  logic                                id_advance_i,
    input  logic [N_REGS-1:0]                   hwlp_dec_cnt_i,
    output logic [N_REGS-1:0][HWLP_DATA_W-1:0]  hwlp_start_addr_o,
    output logic [N_REGS-1:0][HWLP_DATA_W-1:0]  hwlp_end_addr_o,
    output logic [N_REGS-1:0][HWLP_DATA_W-1:0]  hwlp_counter_o,
    output logic [N_REGS-1:0]                   hwlp_active_o,
    output logic [N_REGS-1:0]                   hwlp_dec_cnt_id_o
);

    logic [N_REGS-1:0] sel;

    // An out-of-range loop index matches no entry, so the write is dropped.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            sel[i] = valid_i && (hwlp_regid_i == N_REG_BITS'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwlp_start_addr_o <= '0;
            hwlp_end_addr_o   <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                if (sel[i] && hwlp_we_i[HWLP_WE_START]) begin
                    hwlp_start_addr_o[i] <= hwlp_align(hwlp_start_data_i);
                end
                if (sel[i] && hwlp_we_i[HWLP_WE_END]) begin
                    hwlp_end_addr_o[i] <= hwlp_align(hwlp_end_data_i);
                end
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_cnt
        riscv_hwloop_counter u_counter (
            .clk           (clk),
            .rst_n         (rst_n),
            .cnt_data_i    (hwlp_cnt_data_i),
            .cnt_we_i      (sel[g] && hwlp_we_i[HWLP_WE_CNT]),
            .dec_i         (hwlp_dec_cnt_i[g]),
            .id_advance_i  (id_advance_i),
            .counter_o     (hwlp_counter_o[g]),
            .active_o      (hwlp_active_o[g]),
            .dec_pending_o (hwlp_dec_cnt_id_o[g])
        );
    end

endmodule

// File: tb/tb_riscv_hwloop_regfile.sv
// Directed plus random checks of riscv_hwloop_regfile against a loop-level reference model.
module tb_riscv_hwloop_regfile;

    localparam int unsigned N  = 2;
    localparam int unsigned RB = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [31:0]           hwlp_start_data_i;
    logic [31:0]           hwlp_end_data_i;
    logic [31:0]           hwlp_cnt_data_i;
    logic [2:0]            hwlp_we_i;
    logic [RB-1:0]         hwlp_regid_i;
    logic                  valid_i;
    logic                  id_advance_i;
    logic [N-1:0]          hwlp_dec_cnt_i;
    logic [N-1:0][31:0]    hwlp_start_addr_o;
    logic [N-1:0][31:0]    hwlp_end_addr_o;
    logic [N-1:0][31:0]    hwlp_counter_o;
    logic [N-1:0]          hwlp_active_o;
    logic [N-1:0]          hwlp_dec_cnt_id_o;

    riscv_hwloop_regfile #(.N_REGS(N), .N_REG_BITS(RB)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hwlp_start_data_i (hwlp_start_data_i),
        .hwlp_end_data_i   (hwlp_end_data_i),
        .hwlp_cnt_data_i   (hwlp_cnt_data_i),
        .hwlp_we_i         (hwlp_we_i),
        .hwlp_regid_i      (hwlp_regid_i),
        .valid_i           (valid_i),
        .id_advance_i      (id_advance_i),
        .hwlp_dec_cnt_i    (hwlp_dec_cnt_i),
        .hwlp_start_addr_o (hwlp_start_addr_o),
        .hwlp_end_addr_o   (hwlp_end_addr_o),
        .hwlp_counter_o    (hwlp_counter_o),
        .hwlp_active_o     (hwlp_active_o),
        .hwlp_dec_cnt_id_o (hwlp_dec_cnt_id_o)
    );

    always #5 clk = ~clk;

    // Reference model: one record per loop.
    longint m_start [N];
    longint m_end   [N];
    longint m_cnt   [N];
    bit     m_pend  [N];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_start[i] = 0;
            m_end[i]   = 0;
            m_cnt[i]   = 0;
            m_pend[i]  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s start[%0d]", tag, i), hwlp_start_addr_o[i], 32'(m_start[i]));
            check($sformatf("%s end[%0d]", tag, i), hwlp_end_addr_o[i], 32'(m_end[i]));
            check($sformatf("%s cnt[%0d]", tag, i), hwlp_counter_o[i], 32'(m_cnt[i]));
            check($sformatf("%s active[%0d]", tag, i), 32'(hwlp_active_o[i]), (m_cnt[i] > 0) ? 32'd1 : 32'd0);
            check($sformatf("%s pend[%0d]", tag, i), 32'(hwlp_dec_cnt_id_o[i]), 32'(m_pend[i]));
        end
    endtask

    // Present one cycle of inputs, advance the model by the loop rules, then compare.
    task automatic step(input string tag, input logic [2:0] we, input int rid,
                        input logic [31:0] s, input logic [31:0] e, input logic [31:0] c,
                        input bit vld, input bit adv, input logic [N-1:0] dec);
        bit wr_cnt;
        hwlp_we_i         = we;
        hwlp_regid_i      = RB'(rid);
        hwlp_start_data_i = s;
        hwlp_end_data_i   = e;
        hwlp_cnt_data_i   = c;
        valid_i           = vld;
        id_advance_i      = adv;
        hwlp_dec_cnt_i    = dec;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            wr_cnt = vld && (rid == i) && we[2];
            if (vld && rid == i && we[0]) m_start[i] = (longint'(s) / 2) * 2;
            if (vld && rid == i && we[1]) m_end[i]   = (longint'(e) / 2) * 2;
            if (wr_cnt)                     m_cnt[i] = longint'(c);
            else if (dec[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            if (adv || wr_cnt)              m_pend[i] = 1'b0;
            else if (dec[i])                m_pend[i] = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input bit adv);
        step(tag, 3'b000, 0, 32'h0, 32'h0, 32'h0, 1'b0, adv, '0);
    endtask

    initial begin
        rst_n             = 1'b0;
        hwlp_we_i         = '0;
        hwlp_regid_i      = '0;
        hwlp_start_data_i = '0;
        hwlp_end_data_i   = '0;
        hwlp_cnt_data_i   = '0;
        valid_i           = 1'b0;
        id_advance_i      = 1'b0;
        hwlp_dec_cnt_i    = '0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) idle("idle", 1'b0);

        // lp.setup on loop 1; bit 0 of start dropped
        step("setup1", 3'b111, 1, 32'h101, 32'h200, 32'd3, 1'b1, 1'b1, '0);
        check("setup1 start const", hwlp_start_addr_o[1], 32'h100);
        check("setup1 cnt const", hwlp_counter_o[1], 32'd3);

        // loop 0 from 2 counts down and saturates at 0
        step("cnt0=2", 3'b100, 0, 32'h0, 32'h0, 32'd2, 1'b1, 1'b1, '0);
        step("dec a", 3'b000, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b01);
        check("dec a active const", 32'(hwlp_active_o[0]), 32'd1);
        step("dec b", 3'b000, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b01);
        check("dec b active const", 32'(hwlp_active_o[0]), 32'd0);
        step("dec sat", 3'b000, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b01);
        check("dec sat cnt const", hwlp_counter_o[0], 32'd0);

        step("wr beats dec", 3'b100, 0, 32'h0, 32'h0, 32'd5, 1'b1, 1'b1, 2'b01);
        check("wr beats dec const", hwlp_counter_o[0], 32'd5);

        step("wr1 dec0", 3'b100, 1, 32'h0, 32'h0, 32'd9, 1'b1, 1'b1, 2'b01);
        check("wr1 dec0 c0 const", hwlp_counter_o[0], 32'd4);
        check("wr1 dec0 c1 const", hwlp_counter_o[1], 32'd9);

        // invalid instruction must not write
        step("novalid", 3'b111, 0, 32'hdead, 32'hbeef, 32'd77, 1'b0, 1'b1, '0);

        // pending flag
        step("pend set", 3'b000, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10);
        check("pend set const", 32'(hwlp_dec_cnt_id_o[1]), 32'd1);
        idle("pend hold", 1'b0);
        check("pend hold const", 32'(hwlp_dec_cnt_id_o[1]), 32'd1);
        idle("pend clr", 1'b1);
        check("pend clr const", 32'(hwlp_dec_cnt_id_o[1]), 32'd0);
        step("pend adv", 3'b000, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b11);
        check("pend adv const", 32'(hwlp_dec_cnt_id_o), 32'd0);

        // asynchronous reset mid-loop
        step("cnt0=7", 3'b111, 0, 32'h40, 32'h80, 32'd7, 1'b1, 1'b1, '0);
        step("mid loop", 3'b000, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async rst");
        check("async rst cnt const", hwlp_counter_o[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int k = 0; k < 400; k++) begin
            step("rand",
                 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, N - 1)),
                 $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4)),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)),
                 N'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_hwloop_regfile.md
# riscv_hwloop_regfile

Storage side of the RI5CY hardware-loop mechanism. It holds the per-loop start address, end address and iteration counter written by hardware-loop setup instructions in the ID stage. It applies the per-loop decrement requests issued by the hardware-loop controller and exports the stored values back to that controller every cycle. It also tracks which decrements are still in flight in ID, so the controller can avoid a double jump on the last iteration.

## Interface

Parameters:
- N_REGS, default 2: number of hardware loops.
- N_REG_BITS, default $clog2(N_REGS) (minimum 1): width of the loop index.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- hwlp_start_data_i  in  32  start address write data.
- hwlp_end_data_i  in  32  end address write data.
- hwlp_cnt_data_i  in  32  counter write data.
- hwlp_we_i  in  3  write enables: bit0 start, bit1 end, bit2 counter; any combination is legal (lp.setup sets all).
- hwlp_regid_i  in  N_REG_BITS  target loop index.
- valid_i  in  1  ID instruction valid; qualifies every write.
- id_advance_i  in  1  instruction in ID leaves ID this cycle.
- hwlp_dec_cnt_i  in  N_REGS  decrement request per loop, from the controller.
- hwlp_start_addr_o  out  N_REGS×32  stored start addresses.
- hwlp_end_addr_o  out  N_REGS×32  stored end addresses.
- hwlp_counter_o  out  N_REGS×32  stored counters.
- hwlp_active_o  out  N_REGS  counter ≠ 0.
- hwlp_dec_cnt_id_o  out  N_REGS  decrement issued and the end-address instruction is still in ID.

## Operation

- Write: when valid_i=1 and hwlp_we_i[k]=1, the selected field of loop hwlp_regid_i is loaded with the matching data.
  - Start and end addresses are stored with bit 0 forced to 0.
  - Counter is stored unmodified.
  - hwlp_regid_i ≥ N_REGS: write ignored.
- Decrement: hwlp_dec_cnt_i[i]=1 gives counter[i] ← counter[i] − 1.
  - Counter at 0 stays 0 (saturating, never wraps to 0xFFFFFFFF).
  - Multiple bits set: every flagged loop decrements independently.
- Write and decrement on the same loop in the same cycle: the counter write wins and the decrement is dropped.
- Start/end writes do not interact with decrements.
- Write to loop A with a decrement on loop B: both take effect.
- In-flight tracking, per loop:
  - pending[i] is set when hwlp_dec_cnt_i[i]=1 and id_advance_i=0.
  - pending[i] is cleared when id_advance_i=1, or when loop i's counter is written.
  - Decrement coinciding with id_advance_i=1: pending[i] stays 0.
  - hwlp_dec_cnt_id_o = pending.
- hwlp_active_o[i] is combinational from the stored counter[i].

## Timing

- Reset: every start, end and counter register is 0, pending is 0, so all outputs are 0.
- Reset is asynchronous and takes effect mid-operation, including mid-loop.
- Write latency 1: data written on edge n is visible on the outputs after edge n.
- Decrement latency 1: counter outputs update after the edge that samples hwlp_dec_cnt_i.
- No combinational path from any input to hwlp_*_addr_o, hwlp_counter_o or hwlp_dec_cnt_id_o; all are register outputs.
- hwlp_active_o is combinational on register state only.
- No handshake: every write and decrement is accepted in the cycle it is presented.
- No backpressure.

## Structure

- Shared package riscv_defines holds:
  - HWLP_WE_START=0, HWLP_WE_END=1, HWLP_WE_CNT=2 bit indices.
  - The N_REGS default.
- Natural sub-module: riscv_hwloop_counter, one instance per loop.
  - Contains the 32-bit counter, the saturating decrement, write-priority logic and the pending flag.
  - Start and end registers stay in the top module.

## Test plan

- Reset then idle: all outputs 0 and hwlp_active_o=0 for 10 cycles.
- lp.setup to loop 1: we=3'b111, start=0x101, end=0x200, cnt=3. Next cycle: start_o[1]=0x100, end_o[1]=0x200, counter_o[1]=3, active_o[1]=1, loop 0 unchanged.
- Three decrements on loop 0 from cnt=2:
  - Counter goes 2→1→0→0.
  - active_o[0] drops after the second decrement.
- Same-cycle counter write (cnt=5) and decrement on loop 0: counter_o[0]=5.
- Same-cycle counter write to loop 1 and decrement on loop 0: both applied.
- Pending tracking:
  - Decrement with id_advance_i=0: hwlp_dec_cnt_id_o[i]=1 next cycle.
  - It stays 1 while id_advance_i=0 and clears the cycle after id_advance_i=1.
  - Decrement with id_advance_i=1: hwlp_dec_cnt_id_o stays 0.
- rst_n asserted mid-loop (counter=7): outputs go to 0 asynchronously, before the next clk edge.
